// File: rtl/key_event_classifier.sv
// Key event classifier: turns a debounced key level into short-press, long-press
// and double-click pulses, with a running count of emitted events.
module key_event_classifier #(
    parameter int unsigned LONG_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_lvl,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       busy,
    output logic [7:0] evt_cnt
);

    localparam int unsigned MaxTicks = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int unsigned CntW     = (MaxTicks < 2) ? 1 : $clog2(MaxTicks + 1);

    localparam logic [CntW-1:0] LongLast = CntW'(LONG_TICKS - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_TICKS - 1);

    // Degenerate timings would collapse the one-cycle windows the FSM relies on.
    if (LONG_TICKS < 2) begin : g_long_chk
        $error("key_event_classifier: LONG_TICKS must be at least 2");
    end
    if (GAP_TICKS < 2) begin : g_gap_chk
        $error("key_event_classifier: GAP_TICKS must be at least 2");
    end

    typedef enum logic [2:0] {
        StLock,
        StIdle,
        StPress1,
        StGap,
        StHeld
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            dbl_q, dbl_d;
    logic            busy_q, busy_d;
    logic [7:0]      evt_cnt_q, evt_cnt_d;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        short_d   = 1'b0;
        long_d    = 1'b0;
        dbl_d     = 1'b0;

        unique case (state_q)
            // Wait for a low sample so a key held through reset never classifies.
            StLock: begin
                if (!key_lvl) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (key_lvl) begin
                    state_d = StPress1;
                    cnt_d   = '0;
                end
            end
            StPress1: begin
                if (key_lvl) begin
                    if (cnt_q == LongLast) begin
                        long_d  = 1'b1;
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            // A rise always wins over gap expiry, even on the final gap sample.
            StGap: begin
                if (key_lvl) begin
                    dbl_d   = 1'b1;
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!key_lvl) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StLock;
                cnt_d   = '0;
            end
        endcase

        // busy is registered alongside the state so it tracks state_q exactly.
        busy_d    = (state_d != StIdle);
        evt_cnt_d = (short_d || long_d || dbl_d) ? evt_cnt_q + 8'd1 : evt_cnt_q;
    end

    // State and output registers with asynchronous reset into LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLock;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
            busy_q    <= 1'b1;
            evt_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dbl_q     <= dbl_d;
            busy_q    <= busy_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;
    assign evt_cnt      = evt_cnt_q;

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench for key_event_classifier with LONG_TICKS=8, GAP_TICKS=4.
module tb_key_event_classifier;

    localparam int unsigned LongT = 8;
    localparam int unsigned GapT  = 4;

    localparam int unsigned KShort = 1;
    localparam int unsigned KLong  = 2;
    localparam int unsigned KDbl   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_lvl = 1'b0;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       busy;
    logic [7:0] evt_cnt;

    typedef struct {
        int unsigned kind;
        int unsigned cyc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  exp_total = 8'd0;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    logic [2:0]  prev_code = 3'b000;
    logic [2:0]  code;

    key_event_classifier #(
        .LONG_TICKS (LongT),
        .GAP_TICKS  (GapT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_lvl      (key_lvl),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy),
        .evt_cnt      (evt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign code = {double_click, long_press, short_press};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One key sample: drive the level, let the edge take it, settle past the edge.
    task automatic tick(input logic v);
        key_lvl = v;
        @(posedge clk);
        #1;
    endtask

    // The event is expected to be visible right after the edge just taken.
    task automatic push(input int unsigned kind);
        exp_t e;
        exp_total = exp_total + 8'd1;
        e.kind = kind;
        e.cyc  = cyc;
        e.cnt  = exp_total;
        exp_q.push_back(e);
    endtask

    task automatic score();
        exp_t        e;
        int unsigned ones;
        ones = 32'($countones(code));
        check("onehot", ones, 1);
        if (prev_code != 3'b000) check("pulse_width", 32'(prev_code), 0);
        if (exp_q.size() == 0) begin
            check("unexpected_evt", 32'(code), 0);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", 32'(code), e.kind);
            check("evt_cycle", cyc, e.cyc);
            check("evt_cnt", 32'(evt_cnt), 32'(e.cnt));
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (code != 3'b000) score();
        prev_code <= code;
    end

    // n_high high samples (first taken in IDLE), then low until short fires.
    task automatic press_short(input int unsigned n_high);
        for (int i = 0; i < int'(n_high); i++) tick(1'b1);
        tick(1'b0);
        repeat (GapT) tick(1'b0);
        push(KShort);
        check("short_busy_after", 32'(busy), 0);
        check("short_cnt_after", 32'(evt_cnt), 32'(exp_total));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_short", 32'(short_press), 0);
        check("rst_long", 32'(long_press), 0);
        check("rst_dbl", 32'(double_click), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_evt_cnt", 32'(evt_cnt), 0);
        rst_n = 1'b1;
        tick(1'b0);
        check("lock_to_idle_busy", 32'(busy), 0);
        tick(1'b0);

        // Short press: high 3, then low.
        press_short(3);
        check("short_evt_cnt", 32'(evt_cnt), 1);
        tick(1'b0);

        // Long press: high 20, event on the 9th high sample.
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1);
            if (i == LongT + 1) push(KLong);
            if (i == 2) check("press_busy", 32'(busy), 1);
        end
        tick(1'b0);
        tick(1'b0);
        check("long_busy_after", 32'(busy), 0);
        check("long_evt_cnt", 32'(evt_cnt), 2);

        // Double click: high 2, low 2, high 5, low.
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        push(KDbl);
        repeat (4) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("dbl_busy_after", 32'(busy), 0);
        check("dbl_evt_cnt", 32'(evt_cnt), 3);

        // Press of exactly LONG_TICKS high samples is still short.
        press_short(LongT);

        // Gap boundary: 4 low samples in GAP gives short, next rise is a fresh press.
        press_short(2);
        tick(1'b1);
        check("fresh_press_busy", 32'(busy), 1);
        tick(1'b0);
        repeat (GapT) tick(1'b0);
        push(KShort);
        check("fresh_short_cnt", 32'(evt_cnt), 6);

        // Rise on the final gap sample: double click wins over short.
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        repeat (GapT - 1) tick(1'b0);
        tick(1'b1);
        push(KDbl);
        tick(1'b0);
        tick(1'b0);
        check("gap_edge_evt_cnt", 32'(evt_cnt), 7);

        // Asynchronous reset in GAP discards the pending short press.
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b0;
        #2;
        check("async_rst_busy", 32'(busy), 1);
        check("async_rst_evt_cnt", 32'(evt_cnt), 0);
        check("async_rst_short", 32'(short_press), 0);
        exp_total = 8'd0;
        key_lvl = 1'b1;
        repeat (2) tick(1'b1);
        rst_n = 1'b1;
        repeat (8) tick(1'b1);
        check("lock_held_busy", 32'(busy), 1);
        check("lock_held_evt_cnt", 32'(evt_cnt), 0);
        tick(1'b0);
        check("lock_release_busy", 32'(busy), 0);

        // Wrap: 256 back-to-back short presses.
        for (int i = 0; i < 256; i++) press_short(1);
        check("wrap_evt_cnt", 32'(evt_cnt), 0);
        repeat (4) tick(1'b0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
